// File: rtl/log_fpmul_pkg.sv
// Shared types and helpers for the byte-serial Mitchell floating-point multiplier.
// Holds the control FSM state type, flag bit positions and operand classification.
package log_fpmul_pkg;

    typedef enum logic [1:0] {
        StLoad,
        StCompute,
        StSend
    } state_e;

    typedef enum logic [1:0] {
        ClsZero,
        ClsNorm,
        ClsInf,
        ClsNan
    } fp_class_e;

    localparam int unsigned NumFlags      = 3;
    localparam int unsigned FlagUnderflow = 0;
    localparam int unsigned FlagOverflow  = 1;
    localparam int unsigned FlagInvalid   = 2;

    // Fields arrive zero-extended to the widest supported format; subnormals count as zero.
    function automatic fp_class_e fp_class(input logic [7:0]  exp,
                                           input logic [22:0] man,
                                           input logic [7:0]  exp_max);
        if (exp == 8'd0) begin
            return ClsZero;
        end else if (exp == exp_max) begin
            return (man == 23'd0) ? ClsInf : ClsNan;
        end else begin
            return ClsNorm;
        end
    endfunction

endpackage

// File: rtl/log_fpmul_datapath.sv
// Combinational Mitchell log-domain multiply: exponent add plus mantissa add, truncated.
// Special operands and exponent range faults are resolved here in priority order.
module log_fpmul_datapath
    import log_fpmul_pkg::*;
#(
    parameter int unsigned EXP_W = 5,
    parameter int unsigned MAN_W = 10
) (
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic [EXP_W+MAN_W:0] result,
    output logic [NumFlags-1:0]  flags
);

    localparam int unsigned W    = 1 + EXP_W + MAN_W;
    localparam int unsigned BIAS = 2 ** (EXP_W - 1) - 1;
    localparam logic [EXP_W+1:0] BiasV   = (EXP_W + 2)'(BIAS);
    localparam logic [EXP_W+1:0] OvfLim  = (EXP_W + 2)'(2 ** EXP_W - 1);
    localparam logic [7:0]       ExpMax  = 8'(2 ** EXP_W - 1);

    logic             sa, sb, sign;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] ma, mb;
    logic [MAN_W:0]   msum;
    logic [EXP_W+1:0] esum;
    fp_class_e        cls_a, cls_b;
    logic             any_nan, any_inf, any_zero, zero_times_inf, ovf, unf;

    assign sa = a[W-1];
    assign sb = b[W-1];
    assign ea = a[W-2:MAN_W];
    assign eb = b[W-2:MAN_W];
    assign ma = a[MAN_W-1:0];
    assign mb = b[MAN_W-1:0];

    assign sign  = sa ^ sb;
    assign msum  = {1'b0, ma} + {1'b0, mb};
    // Mantissa carry bumps the exponent: log2(1+x) ~ x, so 1+fa+fb >= 2 means one octave up.
    assign esum  = {2'b00, ea} + {2'b00, eb} + (EXP_W + 2)'(msum[MAN_W]) - BiasV;

    assign cls_a = fp_class(8'(ea), 23'(ma), ExpMax);
    assign cls_b = fp_class(8'(eb), 23'(mb), ExpMax);

    assign any_nan        = (cls_a == ClsNan) || (cls_b == ClsNan);
    assign any_inf        = (cls_a == ClsInf) || (cls_b == ClsInf);
    assign any_zero       = (cls_a == ClsZero) || (cls_b == ClsZero);
    assign zero_times_inf = any_inf && any_zero;
    // esum is signed; the MSB marks a negative biased exponent.
    assign ovf            = !esum[EXP_W+1] && (esum >= OvfLim);
    assign unf            = esum[EXP_W+1] || (esum == '0);

    always_comb begin
        result = '0;
        flags  = '0;
        if (any_nan || zero_times_inf) begin
            result[W-2:MAN_W]  = '1;
            result[MAN_W-1]    = 1'b1;
            flags[FlagInvalid] = 1'b1;
        end else if (any_inf) begin
            result[W-1]       = sign;
            result[W-2:MAN_W] = '1;
        end else if (any_zero) begin
            result[W-1] = sign;
        end else if (ovf) begin
            result[W-1]         = sign;
            result[W-2:MAN_W]   = '1;
            flags[FlagOverflow] = 1'b1;
        end else if (unf) begin
            result[W-1]          = sign;
            flags[FlagUnderflow] = 1'b1;
        end else begin
            result = {sign, esum[EXP_W-1:0], msum[MAN_W-1:0]};
        end
    end

endmodule

// File: rtl/log_fpmul_serial_core.sv
// Byte-serial wrapper: collects operand bytes LSB first, computes once, streams the result back.
// All state, including the registered output byte, freezes while ena is low.
module log_fpmul_serial_core
    import log_fpmul_pkg::*;
#(
    parameter int unsigned EXP_W = 5,
    parameter int unsigned MAN_W = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       in_valid,
    input  logic [7:0] a_byte,
    input  logic [7:0] b_byte,
    output logic       busy,
    output logic       out_valid,
    output logic [7:0] out_byte,
    output logic [2:0] flags
);

    localparam int unsigned W     = 1 + EXP_W + MAN_W;
    localparam int unsigned NB    = (W + 7) / 8;
    localparam int unsigned CNT_W = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned IW    = $clog2(W);
    localparam logic [CNT_W-1:0] LastIdx = CNT_W'(NB - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    byte_cnt_q, byte_cnt_d;
    logic [W-1:0]        a_q, a_d, b_q, b_d;
    logic [W-1:0]        result_q, result_d;
    logic [NumFlags-1:0] res_flags_q, res_flags_d;
    logic                out_valid_q, out_valid_d;
    logic [7:0]          out_byte_q, out_byte_d;
    logic [NumFlags-1:0] out_flags_q, out_flags_d;

    logic [W-1:0]        dp_result;
    logic [NumFlags-1:0] dp_flags;
    logic [31:0]         pos_base;

    log_fpmul_datapath #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_datapath (
        .a      (a_q),
        .b      (b_q),
        .result (dp_result),
        .flags  (dp_flags)
    );

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        result_d    = result_q;
        res_flags_d = res_flags_q;
        out_valid_d = out_valid_q;
        out_byte_d  = out_byte_q;
        out_flags_d = out_flags_q;
        pos_base    = 32'(byte_cnt_q) << 3;

        if (ena) begin
            out_valid_d = 1'b0;
            out_byte_d  = '0;
            out_flags_d = '0;
            unique case (state_q)
                StLoad: begin
                    if (in_valid) begin
                        // Bits of the final byte beyond the format width are dropped here.
                        for (int k = 0; k < 8; k++) begin
                            if (pos_base + 32'(k) < W) begin
                                a_d[IW'(pos_base + 32'(k))] = a_byte[k];
                                b_d[IW'(pos_base + 32'(k))] = b_byte[k];
                            end
                        end
                        if (byte_cnt_q == LastIdx) begin
                            byte_cnt_d = '0;
                            state_d    = StCompute;
                        end else begin
                            byte_cnt_d = byte_cnt_q + CNT_W'(1);
                        end
                    end
                end
                StCompute: begin
                    result_d    = dp_result;
                    res_flags_d = dp_flags;
                    byte_cnt_d  = '0;
                    state_d     = StSend;
                end
                StSend: begin
                    out_valid_d = 1'b1;
                    out_flags_d = res_flags_q;
                    for (int k = 0; k < 8; k++) begin
                        if (pos_base + 32'(k) < W) begin
                            out_byte_d[k] = result_q[IW'(pos_base + 32'(k))];
                        end
                    end
                    if (byte_cnt_q == LastIdx) begin
                        byte_cnt_d = '0;
                        state_d    = StLoad;
                    end else begin
                        byte_cnt_d = byte_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    byte_cnt_d = '0;
                    state_d    = StLoad;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StLoad;
            byte_cnt_q  <= '0;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            res_flags_q <= '0;
            out_valid_q <= 1'b0;
            out_byte_q  <= '0;
            out_flags_q <= '0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            result_q    <= result_d;
            res_flags_q <= res_flags_d;
            out_valid_q <= out_valid_d;
            out_byte_q  <= out_byte_d;
            out_flags_q <= out_flags_d;
        end
    end

    assign busy      = (state_q == StCompute) || (state_q == StSend);
    assign out_valid = out_valid_q;
    assign out_byte  = out_byte_q;
    assign flags     = out_flags_q;

endmodule

// File: tb/tb_log_fpmul_serial_core.sv
// Directed bench for the serial Mitchell multiplier: FP16 default plus E4M3 and BF16 builds.
module tb_log_fpmul_serial_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, ena;

    logic       in_valid, busy, out_valid;
    logic [7:0] a_byte, b_byte, out_byte;
    logic [2:0] flags;

    logic       e_in_valid, e_busy, e_out_valid;
    logic [7:0] e_a_byte, e_b_byte, e_out_byte;
    logic [2:0] e_flags;

    logic       g_in_valid, g_busy, g_out_valid;
    logic [7:0] g_a_byte, g_b_byte, g_out_byte;
    logic [2:0] g_flags;

    log_fpmul_serial_core u_fp16 (
        .clk (clk), .rst_n (rst_n), .ena (ena), .in_valid (in_valid),
        .a_byte (a_byte), .b_byte (b_byte), .busy (busy), .out_valid (out_valid),
        .out_byte (out_byte), .flags (flags)
    );

    log_fpmul_serial_core #(.EXP_W (4), .MAN_W (3)) u_e4m3 (
        .clk (clk), .rst_n (rst_n), .ena (ena), .in_valid (e_in_valid),
        .a_byte (e_a_byte), .b_byte (e_b_byte), .busy (e_busy), .out_valid (e_out_valid),
        .out_byte (e_out_byte), .flags (e_flags)
    );

    log_fpmul_serial_core #(.EXP_W (8), .MAN_W (7)) u_bf16 (
        .clk (clk), .rst_n (rst_n), .ena (ena), .in_valid (g_in_valid),
        .a_byte (g_a_byte), .b_byte (g_b_byte), .busy (g_busy), .out_valid (g_out_valid),
        .out_byte (g_out_byte), .flags (g_flags)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic ena_at_edge = 1'b0;

    typedef struct {
        int         cyc;
        logic [7:0] b;
    } rec_t;
    rec_t mon_q[$];

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        ena_at_edge <= ena;
    end

    // A byte counts once, after an enabled edge; frozen cycles do not repeat it.
    always @(negedge clk) begin
        if (ena_at_edge && out_valid) mon_q.push_back(rec_t'{cyc, out_byte});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_op(input logic [15:0] a, input logic [15:0] b);
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            a_byte   = a[8*i +: 8];
            b_byte   = b[8*i +: 8];
            tick();
        end
        in_valid = 1'b0;
        a_byte   = '0;
        b_byte   = '0;
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_r, input logic [2:0] exp_f);
        int          lat;
        logic [15:0] got;
        logic [2:0]  fl;
        send_op(a, b);
        check({tag, ".busy"}, 32'(busy), 32'd1);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, ".lat"}, 32'(lat), 32'd2);
        got[7:0] = out_byte;
        fl       = flags;
        tick();
        check({tag, ".v1"}, 32'(out_valid), 32'd1);
        got[15:8] = out_byte;
        check({tag, ".res"}, 32'(got), 32'(exp_r));
        check({tag, ".flg"}, 32'(fl), 32'(exp_f));
        tick();
        check({tag, ".drop"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [15:0] bb_a [3] = '{16'h3C00, 16'hC000, 16'h4000};
    logic [15:0] bb_b [3] = '{16'h3C00, 16'h4000, 16'h3800};
    logic [15:0] bb_r [3] = '{16'h3C00, 16'hC400, 16'h3C00};

    initial begin
        int          t0;
        int          n;
        logic [15:0] g_res;

        rst_n = 1'b0; ena = 1'b1;
        in_valid = 1'b0; a_byte = '0; b_byte = '0;
        e_in_valid = 1'b0; e_a_byte = '0; e_b_byte = '0;
        g_in_valid = 1'b0; g_a_byte = '0; g_b_byte = '0;
        tick();
        tick();
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.byte", 32'(out_byte), 32'd0);
        check("rst.flags", 32'(flags), 32'd0);
        rst_n = 1'b1;
        tick();

        run_op("mul1", 16'h3E00, 16'h4200, 16'h4400, 3'b000);

        // Back-to-back with in_valid held high through COMPUTE and SEND.
        mon_q.delete();
        for (int op = 0; op < 3; op++) begin
            for (int i = 0; i < 2; i++) begin
                in_valid = 1'b1;
                a_byte   = bb_a[op][8*i +: 8];
                b_byte   = bb_b[op][8*i +: 8];
                tick();
            end
            check("b2b.busy", 32'(busy), 32'd1);
            for (int j = 0; j < 3; j++) begin
                a_byte = 8'hFF;
                b_byte = 8'hFF;
                tick();
            end
        end
        in_valid = 1'b0;
        repeat (3) tick();
        check("b2b.count", 32'(mon_q.size()), 32'd6);
        for (int k = 0; k < 6; k++) begin
            if (k < mon_q.size()) check("b2b.byte", 32'(mon_q[k].b), 32'(bb_r[k/2][8*(k%2) +: 8]));
        end
        if (mon_q.size() >= 6) check("b2b.period", 32'(mon_q[2].cyc - mon_q[0].cyc), 32'd5);

        // Reset after the first operand byte.
        in_valid = 1'b1; a_byte = 8'h00; b_byte = 8'h3C;
        tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        mon_q.delete();
        repeat (6) tick();
        check("rst1.quiet", 32'(mon_q.size()), 32'd0);
        run_op("rst1.next", 16'h3C00, 16'h3C00, 16'h3C00, 3'b000);

        // Reset in the middle of SEND.
        send_op(16'h4000, 16'h3800);
        tick();
        tick();
        check("rst2.sending", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst2.valid", 32'(out_valid), 32'd0);
        check("rst2.byte", 32'(out_byte), 32'd0);
        check("rst2.busy", 32'(busy), 32'd0);
        mon_q.delete();
        repeat (4) tick();
        check("rst2.quiet", 32'(mon_q.size()), 32'd0);
        run_op("rst2.next", 16'h4000, 16'h3800, 16'h3C00, 3'b000);

        run_op("ovf", 16'h7BFF, 16'h7BFF, 16'h7C00, 3'b010);
        run_op("unf", 16'h0400, 16'h0400, 16'h0000, 3'b001);
        run_op("zinf", 16'h0000, 16'h7C00, 16'h7E00, 3'b100);
        run_op("negz", 16'h8000, 16'h3C00, 16'h8000, 3'b000);

        // ena low for 3 cycles between operand bytes and between result bytes.
        mon_q.delete();
        in_valid = 1'b1; a_byte = 8'h00; b_byte = 8'h00;
        tick();
        t0  = cyc;
        ena = 1'b0;
        a_byte = 8'h3E; b_byte = 8'h42;
        repeat (3) tick();
        ena = 1'b1;
        tick();
        in_valid = 1'b0; a_byte = '0; b_byte = '0;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        ena = 1'b0;
        repeat (2) tick();
        check("ena.hold_v", 32'(out_valid), 32'd1);
        check("ena.hold_b", 32'(out_byte), 32'h00);
        tick();
        ena = 1'b1;
        repeat (4) tick();
        check("ena.count", 32'(mon_q.size()), 32'd2);
        if (mon_q.size() >= 2) begin
            check("ena.b0", 32'(mon_q[0].b), 32'h00);
            check("ena.b1", 32'(mon_q[1].b), 32'h44);
            check("ena.lat", 32'(mon_q[0].cyc - t0), 32'd6);
            check("ena.gap", 32'(mon_q[1].cyc - mon_q[0].cyc), 32'd4);
        end

        // E4M3, one byte per operand.
        e_in_valid = 1'b1; e_a_byte = 8'h3C; e_b_byte = 8'h44;
        tick();
        e_in_valid = 1'b0;
        check("e4m3.busy", 32'(e_busy), 32'd1);
        tick();
        check("e4m3.early", 32'(e_out_valid), 32'd0);
        tick();
        check("e4m3.valid", 32'(e_out_valid), 32'd1);
        check("e4m3.res", 32'(e_out_byte), 32'h48);
        check("e4m3.flg", 32'(e_flags), 32'd0);
        tick();
        check("e4m3.drop", 32'(e_out_valid), 32'd0);

        // BF16.
        g_in_valid = 1'b1; g_a_byte = 8'hC0; g_b_byte = 8'h40;
        tick();
        g_a_byte = 8'h3F; g_b_byte = 8'h40;
        tick();
        g_in_valid = 1'b0;
        tick();
        tick();
        check("bf16.v0", 32'(g_out_valid), 32'd1);
        g_res[7:0] = g_out_byte;
        check("bf16.flg", 32'(g_flags), 32'd0);
        tick();
        check("bf16.v1", 32'(g_out_valid), 32'd1);
        g_res[15:8] = g_out_byte;
        check("bf16.res", 32'(g_res), 32'h4080);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
